waterfall_ctrl: RTL and testbench

// Sequencer for the 16-LED waterfall. Generates the 4-bit LED index that drives the registered 4-to-16 decoder.

---
 rtl/waterfall_pkg.sv | 17 +
 rtl/waterfall_tick_gen.sv | 30 +++
 rtl/waterfall_ctrl.sv | 131 +++++++++++++
 tb/tb_waterfall_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/waterfall_pkg.sv
// Shared types and constants for the 16-LED waterfall sequencer.
package waterfall_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] IDX_MAX = 4'd15;
  localparam logic [3:0] IDX_MIN = 4'd0;

  localparam int DIV_W_DEF    = 27;
  localparam int DIV_SLOW_DEF = 50_000_000;
  localparam int DIV_FAST_DEF = 12_500_000;

endpackage

// File: rtl/waterfall_tick_gen.sv
// Prescaler: counts 0..limit-1 while enabled and emits tick on the terminal count.
// The >= compare lets a shortened limit take effect on the very next edge.
module waterfall_tick_gen #(
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] limit,
  output logic             tick
);

  logic [DIV_W-1:0] count_reg;

  assign tick = en && !clr && (count_reg >= limit - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/waterfall_ctrl.sv
// Waterfall LED index sequencer: start/stop/pause FSM stepping a 4-bit index.
// Optional ping-pong mode is compiled in with WF_BOUNCE_EN.
module waterfall_ctrl
  import waterfall_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int DIV_SLOW = DIV_SLOW_DEF,
  parameter int DIV_FAST = DIV_FAST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       speed,
  input  logic       bounce,
  output logic [3:0] led_idx,
  output logic       led_en,
  output logic       busy,
  output logic       wrap
);

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic       en_reg, en_next;
  logic       busy_reg, busy_next;
  logic       wrap_reg, wrap_next;
  logic       dir_reg, dir_next;
  logic       step_dir;
  logic       tick;
  logic [DIV_W-1:0] limit;

  assign limit = speed ? DIV_W'(DIV_FAST) : DIV_W'(DIV_SLOW);

  // Prescaler runs only in RUN and freezes in the stop cycle so PAUSE resumes mid-count.
  waterfall_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((state_reg == RUN) && !stop),
    .clr   (state_reg == IDLE),
    .limit (limit),
    .tick  (tick)
  );

`ifdef WF_BOUNCE_EN
  // In ping-pong mode the running direction is owned by the reversal logic.
  assign step_dir = bounce ? dir_reg : dir;
`else
  logic unused_bounce;
  assign unused_bounce = bounce;
  assign step_dir      = dir;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    en_next    = en_reg;
    busy_next  = busy_reg;
    wrap_next  = 1'b0;
    dir_next   = dir_reg;
    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          state_next = RUN;
          idx_next   = dir ? IDX_MAX : IDX_MIN;
          en_next    = 1'b1;
          busy_next  = 1'b1;
          dir_next   = dir;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = PAUSE;
        end else if (tick) begin
          dir_next  = step_dir;
          idx_next  = step_dir ? idx_reg - 4'd1 : idx_reg + 4'd1;
          wrap_next = step_dir ? (idx_reg == IDX_MIN) : (idx_reg == IDX_MAX);
`ifdef WF_BOUNCE_EN
          if (bounce && !step_dir && idx_reg == IDX_MAX) begin
            idx_next = IDX_MAX - 4'd1;
            dir_next = 1'b1;
          end else if (bounce && step_dir && idx_reg == IDX_MIN) begin
            idx_next = IDX_MIN + 4'd1;
            dir_next = 1'b0;
          end
`endif
        end
      end
      PAUSE: begin
        if (stop) begin
          state_next = IDLE;
          idx_next   = IDX_MIN;
          en_next    = 1'b0;
          busy_next  = 1'b0;
        end else if (start) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = IDX_MIN;
        en_next    = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= IDX_MIN;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
      wrap_reg  <= wrap_next;
      dir_reg   <= dir_next;
    end
  end

  assign led_idx = idx_reg;
  assign led_en  = en_reg;
  assign busy    = busy_reg;
  assign wrap    = wrap_reg;

endmodule

// File: tb/tb_waterfall_ctrl.sv
// Directed self-checking bench for waterfall_ctrl with DIV_SLOW=4, DIV_FAST=2.
// Expectations follow WF_BOUNCE_EN when the macro is defined for the build.
module tb_waterfall_ctrl;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       stop   = 1'b0;
  logic       dir    = 1'b0;
  logic       speed  = 1'b0;
  logic       bounce = 1'b0;
  logic [3:0] led_idx;
  logic       led_en;
  logic       busy;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  waterfall_ctrl #(
    .DIV_W    (27),
    .DIV_SLOW (4),
    .DIV_FAST (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .speed   (speed),
    .bounce  (bounce),
    .led_idx (led_idx),
    .led_en  (led_en),
    .busy    (busy),
    .wrap    (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit after the last edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(3);
    check("rst_idx", led_idx, 0);
    check("rst_en", led_en, 0);
    check("rst_busy", busy, 0);
    check("rst_wrap", wrap, 0);
    rst_n = 1'b1;
    cyc(1);
    check("idle_idx", led_idx, 0);
    check("idle_en", led_en, 0);

    // Up count, slow speed, full wrap
    pulse_start();
    check("up_start_en", led_en, 1);
    check("up_start_busy", busy, 1);
    check("up_start_idx", led_idx, 0);
    cyc(3);
    check("up_idx_c3", led_idx, 0);
    cyc(1);
    check("up_idx_c4", led_idx, 1);
    cyc(4);
    check("up_idx_c8", led_idx, 2);
    cyc(4);
    check("up_idx_c12", led_idx, 3);
    cyc(48);
    check("up_idx_15", led_idx, 15);
    check("up_wrap_pre", wrap, 0);
    cyc(4);
    check("up_idx_wrap", led_idx, 0);
    check("up_wrap", wrap, 1);
    cyc(1);
    check("up_wrap_clr", wrap, 0);
    pulse_stop();
    pulse_stop();
    check("up_off_en", led_en, 0);
    check("up_off_busy", busy, 0);

    // Down count with a mid-run direction flip
    dir = 1'b1;
    pulse_start();
    check("dn_start_idx", led_idx, 15);
    cyc(4);
    check("dn_idx_14", led_idx, 14);
    cyc(8);
    check("dn_idx_12", led_idx, 12);
    dir = 1'b0;
    cyc(4);
    check("flip_idx_13", led_idx, 13);
    pulse_stop();
    pulse_stop();

    // Pause at prescaler count 2, resume, then stop twice
    pulse_start();
    cyc(2);
    pulse_stop();
    check("pause_busy", busy, 1);
    check("pause_en", led_en, 1);
    cyc(20);
    check("pause_hold_idx", led_idx, 0);
    pulse_start();
    cyc(1);
    check("resume_c1_idx", led_idx, 0);
    cyc(1);
    check("resume_c2_idx", led_idx, 1);
    pulse_stop();
    check("pause2_en", led_en, 1);
    pulse_stop();
    check("off_en", led_en, 0);
    check("off_busy", busy, 0);
    check("off_idx", led_idx, 0);

    // start and stop together: IDLE stays IDLE, RUN goes to PAUSE
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    check("both_idle_busy", busy, 0);
    check("both_idle_en", led_en, 0);
    pulse_start();
    cyc(1);
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    check("both_run_busy", busy, 1);
    cyc(8);
    check("both_run_hold", led_idx, 0);
    pulse_stop();
    check("both_run_off", busy, 0);

    // Speed change mid-count, then async reset mid-run
    pulse_start();
    cyc(2);
    speed = 1'b1;
    cyc(1);
    check("spd_tick_next", led_idx, 1);
    cyc(1);
    check("spd_hold", led_idx, 1);
    cyc(1);
    check("spd_step2", led_idx, 2);
    cyc(2);
    check("spd_step3", led_idx, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_idx", led_idx, 0);
    check("arst_en", led_en, 0);
    check("arst_busy", busy, 0);
    check("arst_wrap", wrap, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check("rel_idx", led_idx, 0);
    check("rel_en", led_en, 0);

    // Bounce request at fast speed
    bounce = 1'b1;
    dir    = 1'b0;
    pulse_start();
    cyc(30);
    check("bnc_idx_15", led_idx, 15);
    check("bnc_wrap_pre", wrap, 0);
    cyc(2);
`ifdef WF_BOUNCE_EN
    check("bnc_rev_idx", led_idx, 14);
    check("bnc_rev_wrap", wrap, 1);
    cyc(1);
    check("bnc_wrap_clr", wrap, 0);
    cyc(27);
    check("bnc_idx_0", led_idx, 0);
    check("bnc_wrap_0", wrap, 0);
    cyc(2);
    check("bnc_rev2_idx", led_idx, 1);
    check("bnc_rev2_wrap", wrap, 1);
`else
    check("nobnc_idx", led_idx, 0);
    check("nobnc_wrap", wrap, 1);
    cyc(1);
    check("nobnc_wrap_clr", wrap, 0);
    cyc(1);
    check("nobnc_idx_1", led_idx, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
